// File: rtl/alu_seq_if.sv
// Handshake bundle between operand fetch, alu_seq and the writeback register.
// The flags signal exists only when ALU_FLAGS_EN is defined.
interface alu_seq_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             busy;
`ifdef ALU_FLAGS_EN
    logic [3:0]       flags;

    modport master (output in_valid, A, B, opcode, out_ready,
                    input  in_ready, out_valid, out, busy, flags);
    modport slave  (input  in_valid, A, B, opcode, out_ready,
                    output in_ready, out_valid, out, busy, flags);
`else
    modport master (output in_valid, A, B, opcode, out_ready,
                    input  in_ready, out_valid, out, busy);
    modport slave  (input  in_valid, A, B, opcode, out_ready,
                    output in_ready, out_valid, out, busy);
`endif
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and an iterative half-width multiply.
// Define ALU_FLAGS_EN to add the {neg, ovf, carry, zero} flags output.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int H     = WIDTH / 2;
    localparam int CNT_W = $clog2(H + 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] out_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] mcand;
    logic [H-1:0]     mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_final;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        alu_res = '0;
        case (bus.opcode)
            3'b000:  alu_res = ~bus.A;
            3'b001:  alu_res = bus.A | bus.B;
            3'b010:  alu_res = bus.A ^ bus.B;
            3'b011:  alu_res = bus.A & bus.B;
            3'b101:  alu_res = bus.A + bus.B;
            3'b110:  alu_res = bus.A - bus.B;
            default: alu_res = '0;
        endcase
    end

    // The multiplicand shifts left and the multiplier right, so bit 0 always selects the addend.
    assign mul_final = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_FLAGS_EN
    logic [3:0] flags_q;
    logic       alu_carry;
    logic       alu_ovf;

    always_comb begin
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (bus.opcode)
            3'b101: begin
                alu_carry = (alu_res < bus.A);
                alu_ovf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            3'b110: begin
                alu_carry = (bus.A < bus.B);
                alu_ovf   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            default: ;
        endcase
    end

    assign bus.flags = flags_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
`ifdef ALU_FLAGS_EN
            flags_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        if (bus.opcode == 3'b100) begin
                            mcand  <= {{H{1'b0}}, bus.A[H-1:0]};
                            mplier <= bus.B[H-1:0];
                            acc    <= '0;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= MUL;
                        end else begin
                            out_q       <= alu_res;
`ifdef ALU_FLAGS_EN
                            flags_q     <= {alu_res[WIDTH-1], alu_ovf, alu_carry, alu_res == '0};
`endif
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc    <= mul_final;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(H - 1)) begin
                        out_q       <= mul_final;
`ifdef ALU_FLAGS_EN
                        flags_q     <= {mul_final[WIDTH-1], 2'b00, mul_final == '0};
`endif
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out       = out_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: 8-bit and 16-bit instances against an arithmetic reference model.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  b8 ();
    alu_seq_if #(.WIDTH(16)) b16 ();

    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint sgn(input longint x, input int w);
        return (x >= (longint'(1) << (w - 1))) ? x - (longint'(1) << w) : x;
    endfunction

    // Reference: plain integer arithmetic over the opcode table.
    function automatic void model(input int w, input longint a, input longint b, input logic [2:0] op,
                                  output longint res, output logic [3:0] fl);
        longint mask  = (longint'(1) << w) - 1;
        longint hmask = (longint'(1) << (w / 2)) - 1;
        longint smax  = (longint'(1) << (w - 1)) - 1;
        longint smin  = -(longint'(1) << (w - 1));
        longint sr;
        logic   c = 1'b0;
        logic   v = 1'b0;
        case (op)
            3'b000: res = ~a & mask;
            3'b001: res = a | b;
            3'b010: res = a ^ b;
            3'b011: res = a & b;
            3'b100: res = (a & hmask) * (b & hmask);
            3'b101: begin
                res = (a + b) & mask;
                c   = (a + b) > mask;
                sr  = sgn(a, w) + sgn(b, w);
                v   = (sr > smax) || (sr < smin);
            end
            3'b110: begin
                res = (a - b) & mask;
                c   = a < b;
                sr  = sgn(a, w) - sgn(b, w);
                v   = (sr > smax) || (sr < smin);
            end
            default: res = 0;
        endcase
        fl = {1'((res >> (w - 1)) & 1), v, c, res == 0};
    endfunction

    task automatic drv(input bit w16, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic iv, input logic ordy);
        if (w16) begin
            b16.A = a; b16.B = b; b16.opcode = op; b16.in_valid = iv; b16.out_ready = ordy;
        end else begin
            b8.A = a[7:0]; b8.B = b[7:0]; b8.opcode = op; b8.in_valid = iv; b8.out_ready = ordy;
        end
    endtask

    function automatic logic [15:0] rd_out(input bit w16);
        return w16 ? b16.out : {8'h00, b8.out};
    endfunction
    function automatic logic rd_ready(input bit w16);
        return w16 ? b16.in_ready : b8.in_ready;
    endfunction
    function automatic logic rd_valid(input bit w16);
        return w16 ? b16.out_valid : b8.out_valid;
    endfunction
    function automatic logic rd_busy(input bit w16);
        return w16 ? b16.busy : b8.busy;
    endfunction
`ifdef ALU_FLAGS_EN
    function automatic logic [3:0] rd_flags(input bit w16);
        return w16 ? b16.flags : b8.flags;
    endfunction
`endif

    // One full transaction: accept, latency, result, optional stall with a rival in_valid, handoff.
    task automatic run_op(input bit w16, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                          input int stall, input string tag);
        longint      er;
        logic [3:0]  ef;
        logic [15:0] m = w16 ? 16'hFFFF : 16'h00FF;
        int          h = w16 ? 8 : 4;
        int          lat = 1;
        int          nbusy = 0;
        model(w16 ? 16 : 8, longint'(a & m), longint'(b & m), op, er, ef);
        drv(w16, a, b, op, 1'b1, 1'b0);
        check({tag, ".in_ready"}, rd_ready(w16), 1);
        step();
        drv(w16, 16'($urandom), 16'($urandom), 3'($urandom), 1'b0, 1'b0);
        while (!rd_valid(w16) && lat <= 2 * h + 4) begin
            if (rd_busy(w16)) nbusy++;
            step();
            lat++;
        end
        check({tag, ".latency"}, lat, (op === 3'b100) ? h + 1 : 1);
        check({tag, ".busy_cycles"}, nbusy, (op === 3'b100) ? h : 0);
        check({tag, ".out"}, rd_out(w16), er[15:0]);
`ifdef ALU_FLAGS_EN
        check({tag, ".flags"}, rd_flags(w16), ef);
`endif
        for (int i = 0; i < stall; i++) begin
            drv(w16, ~a, b, 3'b000, 1'b1, 1'b0);
            step();
            check({tag, ".stall_out"}, rd_out(w16), er[15:0]);
            check({tag, ".stall_ready"}, {rd_ready(w16), rd_valid(w16)}, 2'b01);
        end
        drv(w16, a, b, op, 1'b0, 1'b1);
        step();
        drv(w16, a, b, op, 1'b0, 1'b0);
        check({tag, ".handoff"}, {rd_ready(w16), rd_valid(w16)}, 2'b10);
        check({tag, ".out_kept"}, rd_out(w16), er[15:0]);
        if (stall > 0) begin
            step();
            check({tag, ".no_stale_accept"}, {rd_ready(w16), rd_valid(w16), rd_busy(w16)}, 3'b100);
        end
    endtask

    initial begin
        drv(1'b0, 16'h0000, 16'h0000, 3'b101, 1'b1, 1'b0);
        drv(1'b1, 16'h0000, 16'h0000, 3'b101, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        step();
        check("reset.out", rd_out(0), 0);
        check("reset.status", {rd_ready(0), rd_valid(0), rd_busy(0)}, 3'b100);
        check("reset16.status", {rd_ready(1), rd_valid(1), rd_busy(1)}, 3'b100);
`ifdef ALU_FLAGS_EN
        check("reset.flags", rd_flags(0), 0);
`endif
        rst = 1'b0;
        drv(1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0);
        drv(1'b1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0);
        step();
        check("reset.first_cycle_ready", rd_ready(0), 1);

        run_op(0, 16'h00F0, 16'h0020, 3'b101, 0, "add8");
        run_op(0, 16'h003F, 16'h00AB, 3'b100, 0, "mul8");
        run_op(0, 16'h0005, 16'h0007, 3'b110, 6, "sub8_stall");
        run_op(0, 16'h005A, 16'h00C3, 3'bxxx, 1, "opx8");

        // Abort a multiply with reset on its second MUL cycle.
        drv(0, 16'h00FF, 16'h00FF, 3'b100, 1'b1, 1'b0);
        step();
        drv(0, 16'h00FF, 16'h00FF, 3'b100, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort.out", rd_out(0), 0);
        check("abort.status", {rd_ready(0), rd_valid(0), rd_busy(0)}, 3'b100);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort.no_valid", rd_valid(0), 0);
        end
        run_op(0, 16'h000F, 16'h0000, 3'b000, 0, "not8");

        run_op(1, 16'h00FF, 16'h00FF, 3'b100, 0, "mul16");
        run_op(1, 16'h1234, 16'hABCD, 3'b111, 0, "zero16");
        run_op(1, 16'h7FFF, 16'h0001, 3'b101, 2, "ovf16");
        run_op(1, 16'h8000, 16'h0001, 3'b110, 0, "subovf16");

        for (int i = 0; i < 30; i++)
            run_op(0, 16'($urandom), 16'($urandom), 3'($urandom), int'($urandom_range(0, 2)), "rnd8");
        for (int i = 0; i < 12; i++)
            run_op(1, 16'($urandom), 16'($urandom), 3'($urandom), int'($urandom_range(0, 2)), "rnd16");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 8-bit combinational ALU. Opcode map is unchanged. Operand width is set by a parameter.
- Results are registered and held behind a valid/ready pair. The half-width multiply runs iteratively, one bit per cycle, instead of as a combinational array.
- Sits between the operand-fetch stage and the writeback register in the lab datapath.

Parameters:
- WIDTH, 8, operand/result width. Must be even and >= 4. H = WIDTH/2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  A/B/opcode valid.
- in_ready  out  1  block can accept an operation.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- opcode  in  3  operation select.
- out_valid  out  1  out holds a completed result.
- out_ready  in  1  consumer takes the result.
- out  out  WIDTH  registered result.
- busy  out  1  high in MUL state.
- flags  out  4  {neg, ovf, carry, zero}. Present only with ALU_FLAGS_EN.

Behaviour:
- Reset values (synchronous, rst high at an edge):
  - state=IDLE, out=0, out_valid=0, busy=0, flags=0.
  - in_ready=1 from the first cycle after reset.
  - Reset dominates all other inputs. Reset during MUL or DONE aborts the operation and discards its result.
- Opcodes:
  - 000 ~A
  - 001 A|B
  - 010 A^B
  - 011 A&B
  - 100 A[H-1:0]*B[H-1:0], full WIDTH-bit product, never truncated
  - 101 A+B mod 2^WIDTH
  - 110 A-B mod 2^WIDTH
  - 111 zero
- States: IDLE, MUL, DONE.
  - in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state==MUL).
- Accept: an edge with in_valid & in_ready. A, B and opcode are sampled only at that edge; later input changes are ignored.
  - Non-multiply: result written to out at the accepting edge. Goes IDLE->DONE; out_valid high in the next cycle (latency 1).
  - Multiply: accepting edge loads the multiplicand, multiplier and a cleared accumulator, sets the counter to 0, and goes to MUL.
    - Each MUL edge adds the shifted multiplicand when the current multiplier bit is 1, then increments the counter.
    - After H MUL edges: product written to out, MUL->DONE. out_valid first high H+1 cycles after the accept cycle (5 for WIDTH=8).
- DONE: out (and flags) held stable until an edge with out_ready=1, then DONE->IDLE.
  - out keeps its last value after leaving DONE; it is not cleared.
  - No accept in the same cycle as the result handoff. Peak throughput: one op per 2 cycles (non-mul), one per H+2 cycles (mul).
- out_ready outside DONE is ignored. in_valid outside IDLE is ignored; the source must hold it until in_ready.
- Opcode with X/illegal value: treated as 111.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: flags port exists, registered together with out, held in DONE, reset to 0.
  - zero = (result==0).
  - neg = result[WIDTH-1].
  - carry: add = carry-out of A+B; sub = borrow (A<B unsigned); all other ops 0.
  - ovf: signed overflow for add/sub; all other ops 0.
- Undefined: flags port and its logic absent; all other behaviour identical.

Test Plan:
- Reset: rst high 2 cycles with in_valid=1 -> out=0, out_valid=0, busy=0; first cycle after reset in_ready=1.
- Add, WIDTH=8: A=0xF0, B=0x20, op=101, out_ready=1 -> out_valid one cycle after accept, out=0x10. With ALU_FLAGS_EN: carry=1, zero=0, ovf=0, neg=0.
- Multiply, WIDTH=8: A=0x3F, B=0xAB, op=100 (0xF*0xB) -> busy high 4 cycles, out=0xA5, out_valid exactly 5 cycles after the accept cycle.
- Backpressure: sub A=0x05, B=0x07, out_ready=0 for 6 cycles -> out=0xFE held, in_ready=0 throughout; a new in_valid during the stall is not accepted; op completes when out_ready rises. With ALU_FLAGS_EN: carry=1, neg=1.
- Reset mid-multiply: rst asserted on 2nd MUL cycle -> state IDLE, out=0, out_valid never asserts for the aborted op; the next op (~A, A=0x0F) returns 0xF0.
- WIDTH=16 instance: mul A=0x00FF, B=0x00FF -> out=0xFE01 after 9 cycles. Opcode 111 -> out=0. Signed add 0x7FFF+0x0001 with ALU_FLAGS_EN -> ovf=1, neg=1.
